// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// and the iteration counter sizing helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIX   = 2'b10,
        S_WRITE = 2'b11
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int iter_cnt_width(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

    localparam int ITER_CNT_W = iter_cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/hi_lo_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the mul/div unit;
// result side feeds the HI and LO register write ports directly.
interface hi_lo_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [1:0]            Op;
    logic [DATA_WIDTH-1:0] OperandA;
    logic [DATA_WIDTH-1:0] OperandB;
    logic                  Busy;
    logic [DATA_WIDTH-1:0] HiOut;
    logic [DATA_WIDTH-1:0] LoOut;
    logic                  HiWriteEnable;
    logic                  LoWriteEnable;
    logic                  DivByZero;

    modport master (
        output Start, Op, OperandA, OperandB,
        input  Busy, HiOut, LoOut, HiWriteEnable, LoWriteEnable, DivByZero
    );

    modport slave (
        input  Start, Op, OperandA, OperandB,
        output Busy, HiOut, LoOut, HiWriteEnable, LoWriteEnable, DivByZero
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: LSB-first shift-add for multiply, restoring
// shift-subtract for divide (remainder in the high half, quotient in the low).
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    is_div,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    output logic [2*DATA_WIDTH-1:0] acc_next
);
    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] top;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + (acc[0] ? {1'b0, operand} : '0);
        top      = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
        // top < 2*divisor always holds, so the borrow bit alone decides the quotient bit
        diff     = top - {1'b0, operand};
        acc_next = {sum, acc[DATA_WIDTH-1:1]};
        if (is_div) begin
            if (!diff[DATA_WIDTH])
                acc_next = {diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
            else
                acc_next = {top[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and zero-divisor divides skip to WRITE.
module hi_lo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = DATA_WIDTH
) (
    input  logic                Clk,
    input  logic                Reset,
    hi_lo_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = iter_cnt_width(ITERATIONS);
    localparam int W     = DATA_WIDTH;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_div_q;
    logic [2*W-1:0]    acc_q, acc_step;
    logic [W-1:0]      opnd_q;
    logic [W-1:0]      a_raw_q;
    logic              neg_res_q, neg_rem_q, dz_q;
    logic [W-1:0]      hi_q, lo_q;

    logic              in_div, a_neg, b_neg;
    logic [W-1:0]      a_mag, b_mag;
    logic [W-1:0]      fix_hi, fix_lo;
    logic [2*W-1:0]    prod_fix;
`ifdef MULDIV_EARLY_OUT_EN
    logic              early;
`endif

    // request decode (sign handling only matters for MULT/DIV)
    always_comb begin
        in_div = bus.Op[1];
        a_neg  = bus.Op[0] & bus.OperandA[W-1];
        b_neg  = bus.Op[0] & bus.OperandB[W-1];
        a_mag  = a_neg ? (~bus.OperandA + 1'b1) : bus.OperandA;
        b_mag  = b_neg ? (~bus.OperandB + 1'b1) : bus.OperandB;
`ifdef MULDIV_EARLY_OUT_EN
        early  = in_div ? (bus.OperandB == '0)
                        : ((bus.OperandA == '0) || (bus.OperandB == '0));
`endif
    end

    muldiv_step #(.DATA_WIDTH(W)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        if (!is_div_q) begin
            fix_hi = prod_fix[2*W-1:W];
            fix_lo = prod_fix[W-1:0];
        end else if (dz_q) begin
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else begin
            fix_hi = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
            fix_lo = neg_res_q ? (~acc_q[W-1:0] + 1'b1)   : acc_q[W-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early) state_d = S_WRITE;
`endif
                end
            end
            S_RUN:   if (cnt_q == CNT_W'(ITERATIONS-1)) state_d = S_FIX;
            S_FIX:   state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        cnt_q     <= '0;
                        is_div_q  <= in_div;
                        acc_q     <= in_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                        opnd_q    <= in_div ? b_mag : a_mag;
                        a_raw_q   <= bus.OperandA;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= in_div & a_neg;
                        dz_q      <= in_div & (bus.OperandB == '0);
`ifdef MULDIV_EARLY_OUT_EN
                        if (early) begin
                            hi_q <= in_div ? bus.OperandA : '0;
                            lo_q <= in_div ? '1 : '0;
                        end
`endif
                    end
                end
                S_RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy          = (state_q != S_IDLE);
    assign bus.HiWriteEnable = (state_q == S_WRITE);
    assign bus.LoWriteEnable = (state_q == S_WRITE);
    assign bus.DivByZero     = (state_q == S_WRITE) & dz_q;
    assign bus.HiOut         = hi_q;
    assign bus.LoOut         = lo_q;
endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Scoreboard bench for hi_lo_muldiv_unit: reference results are queued at
// Start and checked when the write strobe appears.
module tb_hi_lo_muldiv_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];

    hi_lo_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

    hi_lo_muldiv_unit #(.DATA_WIDTH(32), .ITERATIONS(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        logic zero;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        e.dz = 1'b0;
        case (op)
            2'b00: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            2'b01: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else if (op == 2'b10) begin
                    e.hi = a % b; e.lo = a / b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e.hi = r[31:0]; e.lo = q[31:0];
                end
            end
        endcase
        zero  = op[1] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
        e.due = 34;
`ifdef MULDIV_EARLY_OUT_EN
        if (zero) e.due = 1;
`else
        if (zero) e.due = 34;
`endif
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        exp_t e;
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
        if (track) begin
            model(op, a, b, e);
            e.due = e.due + cyc;
            sbq.push_back(e);
        end
        @(posedge Clk); #1;
        // scramble inputs to show only the Start-cycle values are used
        bus.Start = 1'b0; bus.Op = 2'($urandom); bus.OperandA = $urandom; bus.OperandB = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (bus.Busy && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (bus.Busy) check("idle_timeout", 1, 0);
    endtask

    // write monitor: every strobe must match the oldest queued request
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (bus.HiWriteEnable || bus.LoWriteEnable) begin
                if (sbq.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("hi", bus.HiOut, e.hi);
                    check("lo", bus.LoOut, e.lo);
                    check("div_by_zero", bus.DivByZero, e.dz);
                    check("latency_cycle", cyc, e.due);
                    check("we_pair", {bus.HiWriteEnable, bus.LoWriteEnable}, 2'b11);
                end
            end else if (bus.DivByZero) begin
                check("dbz_outside_write", 1, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", bus.Busy, 0);
        check("rst_hi", bus.HiOut, 0);
        check("rst_lo", bus.LoOut, 0);
        check("rst_we", {bus.HiWriteEnable, bus.LoWriteEnable, bus.DivByZero}, 0);
        Reset = 1'b0;

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
        check("hold_hi", bus.HiOut, 32'hFFFF_FFFE);
        check("hold_lo", bus.LoOut, 32'h0000_0001);
        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1);          wait_idle();
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1);          wait_idle();
        issue(2'b10, 32'd100, 32'd7, 1);                wait_idle();
        issue(2'b10, 32'h64, 32'd0, 1);                 wait_idle();
        issue(2'b11, 32'hFFFF_FFF9, 32'd0, 1);          wait_idle();
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_idle();
        issue(2'b11, 32'd7, 32'hFFFF_FFFE, 1);          wait_idle();
        issue(2'b01, 32'd0, 32'h8000_0000, 1);          wait_idle();
        issue(2'b00, 32'd12345, 32'd0, 1);              wait_idle();

        // second Start while busy is dropped
        issue(2'b00, 32'd6, 32'd7, 1);
        repeat (3) @(posedge Clk);
        #1 bus.Start = 1'b1; bus.Op = 2'b00; bus.OperandA = 32'd2; bus.OperandB = 32'd2;
        @(posedge Clk); #1 bus.Start = 1'b0;
        wait_idle();
        check("busy_start_lo", bus.LoOut, 32'd42);

        // Start coinciding with WRITE is dropped
        issue(2'b10, 32'd100, 32'd7, 1);
        begin
            int n = 0;
            @(negedge Clk);
            while (!bus.HiWriteEnable && n < 100) begin
                @(negedge Clk);
                n++;
            end
            check("write_seen", bus.HiWriteEnable, 1);
        end
        #1 bus.Start = 1'b1; bus.Op = 2'b00; bus.OperandA = 32'd5; bus.OperandB = 32'd5;
        @(posedge Clk); #1 bus.Start = 1'b0;
        @(negedge Clk);
        check("start_in_write_busy", bus.Busy, 0);

        // asynchronous reset mid-divide aborts with no write
        wait_idle();
        issue(2'b11, 32'hFFFF_FF00, 32'd3, 0);
        repeat (8) @(posedge Clk);
        #3 Reset = 1'b1;
        #1;
        check("abort_busy", bus.Busy, 0);
        check("abort_we", {bus.HiWriteEnable, bus.LoWriteEnable}, 0);
        check("abort_lo", bus.LoOut, 0);
        @(posedge Clk); #2 Reset = 1'b0;
        repeat (40) @(posedge Clk);
        issue(2'b00, 32'd3, 32'd3, 1); wait_idle();
        check("post_abort_lo", bus.LoOut, 32'd9);

        for (int i = 0; i < 8; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd0 : $urandom, 1);
            wait_idle();
        end

        repeat (2) @(negedge Clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
